register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register and of every data bus.
REQ-002 Parameter ADDR_W, default 5, register-address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ra  input  ADDR_W  read-port A address (instruction bits 25:21, rs).
REQ-006 rb  input  ADDR_W  read-port B address (instruction bits 20:16, rt).
REQ-007 rw  input  ADDR_W  write address (rd or rt, as selected upstream).
REQ-008 reg_wr  input  1  write enable.
REQ-009 bus_w  input  WIDTH  write data.
REQ-010 bus_a  output  WIDTH  read-port A data.
REQ-011 bus_b  output  WIDTH  read-port B data.

Function
REQ-012 The block SHALL hold 2**ADDR_W registers, R0..R31, each WIDTH bits.
REQ-013 R0 SHALL read as 0 at all times; it SHALL have no storage.
REQ-014 bus_a SHALL equal R[ra] and bus_b SHALL equal R[rb], combinationally, with zero-cycle latency from an address change.
REQ-015 On a rising clk edge with rst=0, reg_wr=1 and rw!=0, R[rw] SHALL load bus_w.
REQ-016 On a rising clk edge with reg_wr=0, no register SHALL change.
REQ-017 A write to rw=0 SHALL be silently discarded; no other register SHALL change.
REQ-018 There is no write-to-read bypass: in the cycle where R[rw] is being written, a read of rw SHALL return the old value, and the new value SHALL appear immediately after the edge.
REQ-019 ra, rb and rw SHALL be fully independent, so ra==rb, ra==rw and rb==rw are all legal in the same cycle.
REQ-020 Exactly one register at most SHALL be written per edge.
REQ-021 Every address value is in range because the register count equals 2**ADDR_W; no out-of-range handling is required.

Reset
REQ-022 On a rising clk edge with rst=1, R1..R31 SHALL all become 0, regardless of reg_wr, rw and bus_w.
REQ-023 rst SHALL have priority over a simultaneous write, so the write is lost.
REQ-024 If rst is asserted mid-operation, the values written before the reset edge SHALL be lost at that edge.
REQ-025 After reset, bus_a and bus_b SHALL read 0 for every address.
REQ-026 Before the first reset edge, register contents are undefined, except that R0 SHALL read 0.

Structure
REQ-027 WIDTH, ADDR_W and the zero-register address constant (0) SHALL live in the shared processor definitions include, with no local redefinition.
REQ-028 Storage SHALL be built from one sub-module, reg_en, instantiated 31 times.
REQ-029 reg_en SHALL be a WIDTH-bit register with enable and synchronous reset, built from the existing dff cell.
REQ-030 Write-enable decode SHALL be a 5-to-32 one-hot decoder gated by reg_wr, with output 0 unused.
REQ-031 Each read port SHALL be a 32:1 WIDTH-bit mux, built from mux_n.

Verification
REQ-032 Reset: write 0xDEADBEEF to R5, then assert rst for one edge and read ra=5 -> bus_a=0x00000000.
REQ-033 Write/read: reg_wr=1, rw=7, bus_w=0x12345678, one edge; then ra=7, rb=7 -> bus_a=bus_b=0x12345678.
REQ-034 Zero register: reg_wr=1, rw=0, bus_w=0xFFFFFFFF, one edge; then ra=0 -> bus_a=0 and all other registers are unchanged.
REQ-035 No bypass: R3=0x1, then write rw=3, bus_w=0x2 while ra=3 -> bus_a=0x1 before the edge and 0x2 after it.
REQ-036 Reset priority: rst=1, reg_wr=1, rw=9, bus_w=0xAAAA5555 on the same edge -> R9 reads 0.
REQ-037 Sweep: write R[i]=i*0x01010101 for i=1..31, then read all 31 on both ports -> every value matches, and reg_wr=0 cycles leave all values unchanged.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared processor definitions: datapath width, register-address width and
// the hard-wired zero-register address used by the register file.
package register_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

endpackage : register_file_pkg

// File: rtl/dff.sv
// Basic WIDTH-bit D flip-flop cell with synchronous active-high reset.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule : dff

// File: rtl/mux_n.sv
// Generic 2**SEL_W : 1 multiplexer of WIDTH-bit words.
module mux_n #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
) (
  input  logic [WIDTH-1:0] din [2**SEL_W],
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] dout
);

  assign dout = din[sel];

endmodule : mux_n

// File: rtl/reg_en.sv
// WIDTH-bit register with load enable and synchronous reset, built on dff.
module reg_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d_next;

  // NOTE: the hold path feeds q back explicitly; a combinational block that
  // left d_next unassigned on some path would infer a latch instead.
  always_comb begin
    d_next = q;
    if (en) d_next = d;
  end

  dff #(.WIDTH(WIDTH)) u_dff (
    .clk (clk),
    .rst (rst),
    .d   (d_next),
    .q   (q)
  );

endmodule : reg_en

// File: rtl/register_file.sv
// Two-read, one-write register file; R0 is hard-wired to zero and has no
// storage, reads are combinational with no write-to-read bypass.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH  = DATA_WIDTH,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rw,
  input  logic              reg_wr,
  input  logic [WIDTH-1:0]  bus_w,
  output logic [WIDTH-1:0]  bus_a,
  output logic [WIDTH-1:0]  bus_b
);

  localparam int NREG = 2**ADDR_W;

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:1]  we;

  assign regs[ZERO_REG] = '0;

  // One-hot write decode gated by reg_wr; the R0 output is never generated,
  // so writes to address 0 are dropped without touching any other register.
  for (genvar i = 1; i < NREG; i++) begin : g_reg
    assign we[i] = reg_wr && (rw == ADDR_W'(i));

    reg_en #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (we[i]),
      .d   (bus_w),
      .q   (regs[i])
    );
  end

  mux_n #(.WIDTH(WIDTH), .SEL_W(ADDR_W)) u_mux_a (
    .din  (regs),
    .sel  (ra),
    .dout (bus_a)
  );

  mux_n #(.WIDTH(WIDTH), .SEL_W(ADDR_W)) u_mux_b (
    .din  (regs),
    .sel  (rb),
    .dout (bus_b)
  );

endmodule : register_file
